// File: rtl/tone_detector_pkg.sv
// Shared audio definitions: sample/period widths and the period-measurement FSM states.
package tone_detector_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PERIOD_W = 16;

  typedef enum logic {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } td_state_e;

endpackage

// File: rtl/tone_detector_zero_cross.sv
// Hysteresis polarity tracker; flags the step on which the signal turns from low to high.
module zero_cross_detector
  import tone_detector_pkg::*;
#(
  parameter int HYST = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       step_in,
  input  logic signed [SAMPLE_W-1:0] amp_in,
  output logic                       rx_out
);

  localparam logic signed [SAMPLE_W-1:0] HI_TH = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] LO_TH = SAMPLE_W'(-HYST);

  logic r_pol;
  logic w_pol_nxt;

  always_comb begin
    w_pol_nxt = r_pol;
    if (step_in) begin
      if (amp_in >= HI_TH) begin
        w_pol_nxt = 1'b1;
      end else if (amp_in <= LO_TH) begin
        w_pol_nxt = 1'b0;
      end
    end
  end

  // Polarity resets high so the first rising edge requires a prior excursion low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pol <= 1'b1;
    end else begin
      r_pol <= w_pol_nxt;
    end
  end

  assign rx_out = ~r_pol & w_pol_nxt;

endmodule

// File: rtl/tone_detector.sv
// Measures the fundamental period of a signed sample stream, averaged over 2^AVG_LOG2 periods.
module tone_detector
  import tone_detector_pkg::*;
#(
  parameter int HYST       = 4,
  parameter int AVG_LOG2   = 2,
  parameter int MAX_PERIOD = 16'hFFFF
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       step_in,
  input  logic signed [SAMPLE_W-1:0] amp_in,
  output logic        [PERIOD_W-1:0] period_out,
  output logic                       valid_out,
  output logic                       lock_out
);

  localparam int                  SUM_W     = PERIOD_W + AVG_LOG2;
  localparam logic [PERIOD_W-1:0] CNT_LAST  = PERIOD_W'(MAX_PERIOD - 1);
  localparam logic [AVG_LOG2-1:0] NPER_LAST = '1;

  td_state_e            r_state, w_state_nxt;
  logic [PERIOD_W-1:0]  r_cnt, w_cnt_nxt;
  logic [SUM_W-1:0]     r_sum, w_sum_nxt;
  logic [AVG_LOG2-1:0]  r_nper, w_nper_nxt;
  logic [PERIOD_W-1:0]  r_period, w_period_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_lock, w_lock_nxt;
  logic                 w_rx;
  logic [SUM_W-1:0]     w_sum_add;

  zero_cross_detector #(
    .HYST(HYST)
  ) u_zcd (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .step_in(step_in),
    .amp_in (amp_in),
    .rx_out (w_rx)
  );

  // The crossing step itself closes the current period, hence the +1.
  assign w_sum_add = r_sum + SUM_W'(r_cnt) + SUM_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sum_nxt    = r_sum;
    w_nper_nxt   = r_nper;
    w_period_nxt = r_period;
    w_valid_nxt  = 1'b0;
    w_lock_nxt   = r_lock;
    if (step_in) begin
      case (r_state)
        SEEK: begin
          if (w_rx) begin
            w_state_nxt = MEASURE;
            w_cnt_nxt   = '0;
            w_sum_nxt   = '0;
            w_nper_nxt  = '0;
          end
        end
        MEASURE: begin
          if (w_rx) begin
            w_cnt_nxt = '0;
            if (r_nper == NPER_LAST) begin
              w_period_nxt = w_sum_add[AVG_LOG2 +: PERIOD_W];
              w_valid_nxt  = 1'b1;
              w_lock_nxt   = 1'b1;
              w_sum_nxt    = '0;
              w_nper_nxt   = '0;
            end else begin
              w_sum_nxt  = w_sum_add;
              w_nper_nxt = r_nper + 1'b1;
            end
          end else if (r_cnt == CNT_LAST) begin
            // No crossing for MAX_PERIOD samples: tone lost, start over.
            w_state_nxt = SEEK;
            w_lock_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_sum_nxt   = '0;
            w_nper_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + PERIOD_W'(1);
          end
        end
        default: begin
          w_state_nxt = SEEK;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= SEEK;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_nper   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_lock   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sum    <= w_sum_nxt;
      r_nper   <= w_nper_nxt;
      r_period <= w_period_nxt;
      r_valid  <= w_valid_nxt;
      r_lock   <= w_lock_nxt;
    end
  end

  assign period_out = r_period;
  assign valid_out  = r_valid;
  assign lock_out   = r_lock;

endmodule

// File: tb/tb_tone_detector.sv
// Self-checking bench for tone_detector: vector table, directed tone scenarios, randomized waves vs a crossing-list model.
module tb_tone_detector;
  import tone_detector_pkg::*;

  localparam int HYST = 4;
  localparam int AVG_LOG2 = 2;
  localparam int MAXP = 200;
  localparam int NAVG = 1 << AVG_LOG2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              step_in = 1'b0;
  logic signed [7:0] amp_in = '0;
  logic [15:0]       period_out;
  logic              valid_out;
  logic              lock_out;

  int n_tests = 0;
  int n_fail = 0;
  int n_pulse = 0;

  // Reference model: works on step indices and a list of completed periods.
  int          m_idx;
  int          m_last;
  bit          m_pol;
  bit          m_meas;
  int          m_per[$];
  logic [15:0] m_period;
  bit          m_valid;
  bit          m_lock;

  typedef struct {
    logic rst;
    logic stp;
    int   amp;
    logic v;
    logic l;
    int   p;
  } vec_t;

  vec_t tbl[18];

  tone_detector #(
    .HYST(HYST),
    .AVG_LOG2(AVG_LOG2),
    .MAX_PERIOD(MAXP)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .step_in(step_in),
    .amp_in(amp_in),
    .period_out(period_out),
    .valid_out(valid_out),
    .lock_out(lock_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic model_step(input bit rst, input bit stp, input int amp);
    bit prev;
    bit rx;
    int s;
    m_valid = 1'b0;
    if (rst) begin
      m_pol = 1'b1;
      m_meas = 1'b0;
      m_per.delete();
      m_period = '0;
      m_lock = 1'b0;
      m_idx = 0;
      m_last = 0;
      return;
    end
    if (!stp) return;
    m_idx++;
    prev = m_pol;
    if (amp >= HYST) m_pol = 1'b1;
    else if (amp <= -HYST) m_pol = 1'b0;
    rx = !prev && m_pol;
    if (rx) begin
      if (m_meas) begin
        m_per.push_back(m_idx - m_last);
        if (m_per.size() == NAVG) begin
          s = 0;
          foreach (m_per[k]) s += m_per[k];
          m_period = 16'(s / NAVG);
          m_valid = 1'b1;
          m_lock = 1'b1;
          m_per.delete();
        end
      end
      m_meas = 1'b1;
      m_last = m_idx;
    end else if (m_meas && (m_idx - m_last) == MAXP) begin
      m_meas = 1'b0;
      m_lock = 1'b0;
      m_per.delete();
    end
  endtask

  task automatic drive(input bit rst, input bit stp, input logic signed [7:0] amp, input string nm);
    rst_in = rst;
    step_in = stp;
    amp_in = amp;
    @(posedge clk_in);
    model_step(rst, stp, int'(amp));
    #1;
    n_tests++;
    if ({valid_out, lock_out, period_out} !== {m_valid, m_lock, m_period}) begin
      n_fail++;
      $display("FAIL %s @%0t: got v=%0b l=%0b p=%0d, expected v=%0b l=%0b p=%0d",
               nm, $time, valid_out, lock_out, period_out, m_valid, m_lock, m_period);
    end
    if (valid_out === 1'b1) n_pulse++;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Sawtooth -128..124 with period 64; gap idle cycles (random amp) after each step.
  task automatic saw(input int n, input int gap, output int first);
    int p0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      p0 = n_pulse;
      drive(1'b0, 1'b1, 8'(-128 + 4 * (i % 64)), "saw");
      if (n_pulse != p0 && first < 0) first = i;
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'($urandom), "saw_gap");
    end
  endtask

  task automatic sq(input int amp, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 8'(amp), "square");
  endtask

  task automatic rnd_step(input int a);
    while ($urandom_range(3, 0) == 0) drive(1'b0, 1'b0, 8'($urandom), "rnd_idle");
    drive(1'b0, 1'b1, 8'(a), "rnd");
  endtask

  initial begin
    int first;
    int p0;
    int kind;
    int len;
    int per;
    int hi;
    int reps;
    int a;

    // Reset state
    drive(1'b1, 1'b0, 8'sd0, "reset");
    check("reset_outputs", int'({valid_out, lock_out, period_out}), 0);
    check("reset_state", int'(dut.r_state), int'(SEEK));

    // Table: sub-hysteresis wiggle, then a period-2 square wave closing one window
    tbl[0]  = '{1'b1, 1'b0,    0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1,    3, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1,   -3, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1,    3, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1,   -3, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b1,   -4, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b1,    4, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b1,   -4, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b1,    4, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b1,   -4, 1'b0, 1'b0, 0};
    tbl[10] = '{1'b0, 1'b1,    4, 1'b0, 1'b0, 0};
    tbl[11] = '{1'b0, 1'b1,   -4, 1'b0, 1'b0, 0};
    tbl[12] = '{1'b0, 1'b1,    4, 1'b0, 1'b0, 0};
    tbl[13] = '{1'b0, 1'b1,   -4, 1'b0, 1'b0, 0};
    tbl[14] = '{1'b0, 1'b1,    4, 1'b1, 1'b1, 2};
    tbl[15] = '{1'b0, 1'b0, -100, 1'b0, 1'b1, 2};
    tbl[16] = '{1'b0, 1'b1,   -4, 1'b0, 1'b1, 2};
    tbl[17] = '{1'b0, 1'b1,    4, 1'b0, 1'b1, 2};
    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].rst, tbl[k].stp, 8'(tbl[k].amp), "table_model");
      check($sformatf("table[%0d] {v,l,p}", k), int'({valid_out, lock_out, period_out}),
            int'({tbl[k].v, tbl[k].l, 16'(tbl[k].p)}));
    end

    // Sawtooth period 64 every cycle: pulses at samples 289, 545, 801
    drive(1'b1, 1'b0, 8'sd0, "reset");
    p0 = n_pulse;
    saw(802, 0, first);
    check("saw_first_pulse_idx", first, 289);
    check("saw_pulse_count", n_pulse - p0, 3);
    check("saw_period", int'(period_out), 64);
    check("saw_lock", int'(lock_out), 1);

    // Timeout: amp held at 0, lock drops on the 200th step after the last crossing
    p0 = n_pulse;
    for (int i = 0; i < MAXP - 1; i++) drive(1'b0, 1'b1, 8'sd0, "timeout");
    check("timeout_lock_before", int'(lock_out), 1);
    drive(1'b0, 1'b1, 8'sd0, "timeout");
    check("timeout_lock_after", int'(lock_out), 0);
    check("timeout_no_pulse", n_pulse - p0, 0);
    check("timeout_period_held", int'(period_out), 64);
    check("timeout_state", int'(dut.r_state), int'(SEEK));

    // Mid-window reset while locked
    drive(1'b1, 1'b0, 8'sd0, "reset");
    saw(900, 0, first);
    check("pre_rst_lock", int'(lock_out), 1);
    drive(1'b1, 1'b1, 8'sd100, "mid_reset");
    check("mid_rst_outputs", int'({valid_out, lock_out, period_out}), 0);
    check("mid_rst_state", int'(dut.r_state), int'(SEEK));
    p0 = n_pulse;
    saw(400, 0, first);
    check("post_rst_first_pulse", first, 289);
    check("post_rst_pulse_count", n_pulse - p0, 1);
    check("post_rst_period", int'(period_out), 64);

    // Sawtooth with step_in one cycle in three
    drive(1'b1, 1'b0, 8'sd0, "reset");
    p0 = n_pulse;
    saw(802, 2, first);
    check("slow_first_pulse_idx", first, 289);
    check("slow_pulse_count", n_pulse - p0, 3);
    check("slow_period", int'(period_out), 64);

    // Square wave +-100, periods 63,65,63,65
    drive(1'b1, 1'b0, 8'sd0, "reset");
    p0 = n_pulse;
    sq(-100, 5);
    sq(100, 32); sq(-100, 31);
    sq(100, 33); sq(-100, 32);
    sq(100, 32); sq(-100, 31);
    sq(100, 33); sq(-100, 32);
    sq(100, 1);
    check("square_pulse_count", n_pulse - p0, 1);
    check("square_period", int'(period_out), 64);
    check("square_lock", int'(lock_out), 1);

    // +3/-3 below hysteresis: never crosses
    drive(1'b1, 1'b0, 8'sd0, "reset");
    p0 = n_pulse;
    for (int i = 0; i < 60; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 8'sd3 : -8'sd3, "sub_hyst");
    check("sub_hyst_pulses", n_pulse - p0, 0);
    check("sub_hyst_lock", int'(lock_out), 0);
    check("sub_hyst_state", int'(dut.r_state), int'(SEEK));

    // Randomized square-ish waves, idle runs and resets against the model
    drive(1'b1, 1'b0, 8'sd0, "reset");
    for (int b = 0; b < 60; b++) begin
      kind = $urandom_range(19, 0);
      if (kind == 0) begin
        drive(1'b1, 1'b0, 8'($urandom), "rnd_reset");
      end else if (kind < 3) begin
        len = $urandom_range(260, 150);
        for (int i = 0; i < len; i++) rnd_step($urandom_range(6, 0) - 3);
      end else begin
        per = $urandom_range(120, 2);
        hi = $urandom_range(per - 1, 1);
        reps = $urandom_range(5, 1);
        for (int r = 0; r < reps; r++) begin
          for (int j = 0; j < per; j++) begin
            if ($urandom_range(7, 0) == 0) a = $urandom_range(6, 0) - 3;
            else if (j < hi) a = $urandom_range(127, HYST);
            else a = -int'($urandom_range(128, HYST));
            rnd_step(a);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
